// File: rtl/divider_taint_track.sv
// Restoring unsigned divider, one quotient bit per cycle, with conservative per-bit taint shadows.
// Control taint is sticky until reset and forces all result shadows high when set.
module divider_taint_track #(
   parameter int unsigned WIDTH = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             start_t,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] dividend_t,
   input  logic [WIDTH-1:0] divisor,
   input  logic [WIDTH-1:0] divisor_t,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] quotient_t,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] remainder_t,
   output logic             quotientDone,
   output logic             quotientDone_t
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] ITER = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem, rem_t;
   logic [WIDTH-1:0] dq, dq_t, dv, dv_t;
   logic             ctrl_taint;

   logic [WIDTH:0]   rem_s, rem_ts, dv_ext, dvt_ext, rem_n, rem_tn, smear;
   logic [WIDTH-1:0] dq_n, dq_tn;
   logic             sub, cmp_t, acc;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = ITER;
         ITER:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One restoring step; a subtract smears any operand taint upward through the borrow chain
   always_comb begin
      rem_s   = {rem[WIDTH-1:0], dq[WIDTH-1]};
      rem_ts  = {rem_t[WIDTH-1:0], dq_t[WIDTH-1]};
      dv_ext  = {1'b0, dv};
      dvt_ext = {1'b0, dv_t};
      sub     = (rem_s >= dv_ext);
      cmp_t   = (|rem_ts) | (|dv_t);
      rem_n   = sub ? (rem_s - dv_ext) : rem_s;
      smear   = '0;
      acc     = 1'b0;
      for (int unsigned i = 0; i <= WIDTH; i++) begin
         acc      = acc | rem_ts[i] | dvt_ext[i];
         smear[i] = acc;
      end
      if (cmp_t)    rem_tn = '1;
      else if (sub) rem_tn = smear;
      else          rem_tn = rem_ts;
      dq_n  = {dq[WIDTH-2:0], sub};
      dq_tn = {dq_t[WIDTH-2:0], cmp_t};
   end

   // Datapath, result registers and sticky control taint
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= '0;
         rem          <= '0;
         rem_t        <= '0;
         dq           <= '0;
         dq_t         <= '0;
         dv           <= '0;
         dv_t         <= '0;
         ctrl_taint   <= 1'b0;
         quotient     <= '0;
         quotient_t   <= '0;
         remainder    <= '0;
         remainder_t  <= '0;
         quotientDone <= 1'b0;
      end else begin
         quotientDone <= 1'b0;
         case (state)
            IDLE: begin
               if (start_t) ctrl_taint <= 1'b1;
               if (start) begin
                  dq   <= dividend;
                  dq_t <= dividend_t;
                  dv   <= divisor;
                  dv_t <= divisor_t;
               end
            end
            LOAD: begin
               rem   <= '0;
               rem_t <= '0;
               cnt   <= CW'(WIDTH - 1);
            end
            ITER: begin
               rem   <= rem_n;
               rem_t <= rem_tn;
               dq    <= dq_n;
               dq_t  <= dq_tn;
               cnt   <= cnt - CW'(1);
            end
            DONE: begin
               quotient     <= dq;
               remainder    <= rem[WIDTH-1:0];
               quotient_t   <= ctrl_taint ? '1 : dq_t;
               remainder_t  <= ctrl_taint ? '1 : rem_t[WIDTH-1:0];
               quotientDone <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign quotientDone_t = ctrl_taint;

endmodule

// File: tb/tb_divider_taint_track.sv
// Randomized and directed bench for divider_taint_track against a behavioural division/taint model.
module tb_divider_taint_track;

   localparam int unsigned W = 8;

   logic         clk, rst, start, start_t;
   logic [W-1:0] dividend, dividend_t, divisor, divisor_t;
   logic [W-1:0] quotient, quotient_t, remainder, remainder_t;
   logic         quotientDone, quotientDone_t;

   divider_taint_track #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .start_t(start_t),
      .dividend(dividend), .dividend_t(dividend_t),
      .divisor(divisor), .divisor_t(divisor_t),
      .quotient(quotient), .quotient_t(quotient_t),
      .remainder(remainder), .remainder_t(remainder_t),
      .quotientDone(quotientDone), .quotientDone_t(quotientDone_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Expected visible outputs and the one pending result
   logic [W-1:0] hold_q = '0, hold_r = '0, hold_qt = '0, hold_rt = '0;
   logic [W-1:0] pend_q, pend_r, pend_qt, pend_rt;
   bit           pend_valid = 0;
   int           pend_cycle = 0;
   bit           ctrl_set   = 0;
   int           ctrl_from  = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Division result plus taint: once any tainted bit reaches the comparison, every later
   // quotient bit and the whole remainder are tainted.
   function automatic void model(input logic [W-1:0] a, b, at, bt,
                                 output logic [W-1:0] q, r, qt, rt);
      bit tainted = 0;
      if (b == 0) begin q = '1; r = a; end
      else begin q = a / b; r = a % b; end
      qt = '0;
      for (int i = W - 1; i >= 0; i--) begin
         tainted = tainted | at[i] | (bt != 0);
         qt[i]   = tainted;
      end
      rt = tainted ? '1 : '0;
   endfunction

   // Compare process: every cycle the full output set is checked against the model
   always @(negedge clk) begin
      logic exp_done;
      cyc++;
      exp_done = 1'b0;
      if (pend_valid && cyc == pend_cycle) begin
         hold_q = pend_q; hold_r = pend_r; hold_qt = pend_qt; hold_rt = pend_rt;
         pend_valid = 0;
         exp_done   = 1'b1;
      end
      chk("done",        W'(quotientDone), W'(exp_done));
      chk("done_t",      W'(quotientDone_t), W'(ctrl_set && cyc >= ctrl_from));
      chk("quotient",    quotient, hold_q);
      chk("remainder",   remainder, hold_r);
      chk("quotient_t",  quotient_t, hold_qt);
      chk("remainder_t", remainder_t, hold_rt);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Issue one division; caller is at negedge+1 with the DUT idle
   task automatic go(input logic [W-1:0] a, b, at, bt, input logic st);
      logic [W-1:0] q, r, qt, rt;
      start = 1'b1; start_t = st;
      dividend = a; divisor = b; dividend_t = at; divisor_t = bt;
      if (st && !ctrl_set) begin ctrl_set = 1; ctrl_from = cyc + 1; end
      model(a, b, at, bt, q, r, qt, rt);
      if (ctrl_set) begin qt = '1; rt = '1; end
      pend_q = q; pend_r = r; pend_qt = qt; pend_rt = rt;
      pend_cycle = cyc + W + 3;
      pend_valid = 1;
      step();
      start = 1'b0; start_t = 1'b0;
      dividend = W'($urandom); divisor = W'($urandom);
      dividend_t = W'($urandom); divisor_t = W'($urandom);
   endtask

   task automatic wait_done();
      int budget = W + 10;
      while (pend_valid && budget > 0) begin
         step();
         budget--;
      end
      if (pend_valid) begin
         tests++; fails++;
         $display("FAIL wait_done: result not delivered within %0d cycles", W + 10);
         pend_valid = 0;
      end
   endtask

   task automatic reset_model();
      hold_q = '0; hold_r = '0; hold_qt = '0; hold_rt = '0;
      pend_valid = 0; ctrl_set = 0;
   endtask

   initial begin
      logic [W-1:0] q, r, qt, rt, a, b, at, bt;
      rst = 1'b0; start = 1'b0; start_t = 1'b0;
      dividend = '0; divisor = '0; dividend_t = '0; divisor_t = '0;

      // Pin the model with hand-computed values
      model(8'd100, 8'd7, 8'h00, 8'h00, q, r, qt, rt);
      chk("model_100_7_q", q, 8'd14); chk("model_100_7_r", r, 8'd2);
      chk("model_100_7_qt", qt, 8'h00); chk("model_100_7_rt", rt, 8'h00);
      model(8'd37, 8'd0, 8'h00, 8'h00, q, r, qt, rt);
      chk("model_div0_q", q, 8'hFF); chk("model_div0_r", r, 8'd37);
      model(8'd100, 8'd7, 8'h01, 8'h00, q, r, qt, rt);
      chk("model_dvdt_qt", qt, 8'h01); chk("model_dvdt_rt", rt, 8'hFF);
      model(8'd100, 8'd7, 8'h00, 8'h01, q, r, qt, rt);
      chk("model_dvst_qt", qt, 8'hFF); chk("model_dvst_rt", rt, 8'hFF);
      model(8'd200, 8'd13, 8'h00, 8'h00, q, r, qt, rt);
      chk("model_200_13_q", q, 8'd15); chk("model_200_13_r", r, 8'd5);

      repeat (3) step();
      rst = 1'b1;
      step();

      // Directed cases
      go(8'd100, 8'd7, 8'h00, 8'h00, 1'b0); wait_done();
      chk("t1_q", quotient, 8'd14); chk("t1_r", remainder, 8'd2);
      chk("t1_qt", quotient_t, 8'h00); chk("t1_dt", W'(quotientDone_t), 8'h00);
      go(8'd37, 8'd0, 8'h00, 8'h00, 1'b0); wait_done();
      chk("t2_q", quotient, 8'hFF); chk("t2_r", remainder, 8'd37);
      go(8'd100, 8'd7, 8'h01, 8'h00, 1'b0); wait_done();
      chk("t3_qt", quotient_t, 8'h01); chk("t3_rt", remainder_t, 8'hFF);
      go(8'd100, 8'd7, 8'h00, 8'h01, 1'b0); wait_done();
      chk("t4_qt", quotient_t, 8'hFF); chk("t4_rt", remainder_t, 8'hFF);

      // Random operands and sparse data taint, mixing back-to-back and gapped starts
      for (int n = 0; n < 40; n++) begin
         a  = W'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, (n % 2) ? 255 : 15));
         at = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : 8'h00;
         bt = ($urandom_range(0, 5) == 0) ? W'(1 << $urandom_range(0, W - 1)) : 8'h00;
         go(a, b, at, bt, 1'b0);
         wait_done();
         repeat ($urandom_range(0, 2)) step();
      end

      // Start during ITER is ignored; reset mid-ITER aborts
      go(8'd100, 8'd7, 8'h00, 8'h00, 1'b0);
      step();
      start = 1'b1; dividend = 8'd50; divisor = 8'd3;
      step();
      start = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      reset_model();
      repeat (2) step();
      rst = 1'b1;
      step();
      go(8'd200, 8'd13, 8'h00, 8'h00, 1'b0); wait_done();
      chk("t6_q", quotient, 8'd15); chk("t6_r", remainder, 8'd5);

      // Control taint sampled with start low, then sticky across operations
      start_t = 1'b1; ctrl_set = 1; ctrl_from = cyc + 1;
      step();
      start_t = 1'b0;
      step();
      go(8'd9, 8'd3, 8'h00, 8'h00, 1'b0); wait_done();
      chk("t5_q", quotient, 8'd3); chk("t5_r", remainder, 8'd0);
      chk("t5_qt", quotient_t, 8'hFF); chk("t5_rt", remainder_t, 8'hFF);
      chk("t5_dt", W'(quotientDone_t), 8'h01);
      for (int n = 0; n < 6; n++) begin
         go(W'($urandom), W'($urandom_range(0, 40)), 8'h00, 8'h00, 1'($urandom_range(0, 1)));
         wait_done();
      end

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
